// File: rtl/ks_add_arbiter.sv
// rtl/ks_add_arbiter.sv - two-requester arbiter feeding a pipelined 16-bit Kogge-Stone adder; define KSA_ARB_FIXED_PRI_EN for fixed priority (req0 wins ties)
module ks_add_arbiter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id,
    output logic [CNT_W-1:0] ops_cnt
);
    localparam int LEVELS = $clog2(WIDTH);

    logic             adv1;
    logic             adv2;
    logic             grant_valid;
    logic             grant_id;
    logic             accept;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_cin;
    logic             s1_id;
    logic [WIDTH-1:0] ks_sum;
    logic             ks_cout;

    // The result register advances when empty or drained; stage 1 advances when empty or able to move on.
    assign adv2 = !res_valid | res_ready;
    assign adv1 = !s1_valid | adv2;

`ifdef KSA_ARB_FIXED_PRI_EN
    // Fixed priority: requester 0 wins whenever it is requesting.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_id    = !req0_valid;
    end
`else
    logic last;

    // Round-robin: on a tie the requester that did not win last time is granted.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = !last;
        end else begin
            grant_id = req1_valid;
        end
    end

    // Remember the most recently accepted requester; reset value lets req0 win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= grant_id;
        end
    end
`endif

    assign accept     = adv1 & grant_valid;
    assign req0_ready = adv1 & grant_valid & !grant_id;
    assign req1_ready = adv1 & grant_valid & grant_id;

    // Operand register: capture the granted operation, empty out when nothing is accepted, hold when blocked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_cin   <= 1'b0;
            s1_id    <= 1'b0;
        end else if (adv1) begin
            s1_valid <= accept;
            if (accept) begin
                s1_a   <= grant_id ? req1_a : req0_a;
                s1_b   <= grant_id ? req1_b : req0_b;
                s1_cin <= grant_id ? req1_cin : req0_cin;
                s1_id  <= grant_id;
            end
        end
    end

    // Kogge-Stone prefix tree on the operand register; carry-in is folded into bit 0's generate.
    always_comb begin
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] gn;
        logic [WIDTH-1:0] pn;
        g    = s1_a & s1_b;
        p    = s1_a ^ s1_b;
        g[0] = g[0] | (p[0] & s1_cin);
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            gn = g;
            pn = p;
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << lvl)) begin
                    gn[i] = g[i] | (p[i] & g[i - (1 << lvl)]);
                    pn[i] = p[i] & p[i - (1 << lvl)];
                end
            end
            g = gn;
            p = pn;
        end
        ks_sum  = (s1_a ^ s1_b) ^ {g[WIDTH-2:0], s1_cin};
        ks_cout = g[WIDTH-1];
    end

    // Result register: load from stage 1 when advancing, otherwise hold steady for the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            res_id    <= 1'b0;
        end else if (adv2) begin
            res_valid <= s1_valid;
            if (s1_valid) begin
                res_sum  <= ks_sum;
                res_cout <= ks_cout;
                res_id   <= s1_id;
            end
        end
    end

    // Count delivered results, wrapping naturally at the counter width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_cnt <= '0;
        end else if (res_valid && res_ready) begin
            ops_cnt <= ops_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_ks_add_arbiter.sv
// tb/tb_ks_add_arbiter.sv - self-checking bench for ks_add_arbiter against a two-slot pipeline reference model
module tb_ks_add_arbiter;
    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req0_ready, req0_cin;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic             req1_valid, req1_ready, req1_cin;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic             res_valid, res_ready, res_cout, res_id;
    logic [WIDTH-1:0] res_sum;
    logic [CNT_W-1:0] ops_cnt;

    ks_add_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout),
        .res_id(res_id), .ops_cnt(ops_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH:0] total;
        logic           id;
        int             age;
    } op_t;

    op_t  pipe_q[$];
    int   checks = 0;
    int   errors = 0;
    int   model_cnt = 0;
    logic model_last = 1'b1;
    logic exp_r0, exp_r1, exp_rv;
    logic acc0 = 1'b0, acc1 = 1'b0;
    int   dut_accepts = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [WIDTH:0] add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    endfunction

    task automatic compare();
        logic both, gid, space;
        both = req0_valid && req1_valid;
`ifdef KSA_ARB_FIXED_PRI_EN
        gid = both ? 1'b0 : req1_valid;
`else
        gid = both ? !model_last : req1_valid;
`endif
        space  = (pipe_q.size() < 2) || res_ready;
        exp_r0 = space && req0_valid && !gid;
        exp_r1 = space && req1_valid && gid;
        exp_rv = (pipe_q.size() > 0) && (pipe_q[0].age >= 1);
        if (req0_valid && req0_ready) dut_accepts++;
        if (req1_valid && req1_ready) dut_accepts++;
        check("req0_ready", req0_ready, exp_r0);
        check("req1_ready", req1_ready, exp_r1);
        check("res_valid", res_valid, exp_rv);
        if (exp_rv) begin
            check("res_sum", res_sum, pipe_q[0].total[WIDTH-1:0]);
            check("res_cout", res_cout, pipe_q[0].total[WIDTH]);
            check("res_id", res_id, pipe_q[0].id);
        end
        check("ops_cnt", ops_cnt, model_cnt % 256);
    endtask

    task automatic update_model();
        op_t t;
        if (exp_rv && res_ready) begin
            void'(pipe_q.pop_front());
            model_cnt++;
        end
        for (int i = 0; i < pipe_q.size(); i++) begin
            t = pipe_q[i];
            t.age++;
            pipe_q[i] = t;
        end
        acc0 = exp_r0;
        acc1 = exp_r1;
        if (acc0) begin
            t.total = add(req0_a, req0_b, req0_cin); t.id = 1'b0; t.age = 0;
            pipe_q.push_back(t);
            model_last = 1'b0;
        end
        if (acc1) begin
            t.total = add(req1_a, req1_b, req1_cin); t.id = 1'b1; t.age = 0;
            pipe_q.push_back(t);
            model_last = 1'b1;
        end
    endtask

    task automatic cycle();
        #1 compare();
        @(posedge clk);
        update_model();
        @(negedge clk);
        if (acc0) req0_valid = 1'b0;
        if (acc1) req1_valid = 1'b0;
    endtask

    task automatic gen(input int unsigned p0, input int unsigned p1, input int unsigned pr);
        if (!req0_valid && $urandom_range(99) < p0) begin
            req0_valid = 1'b1; req0_a = WIDTH'($urandom); req0_b = WIDTH'($urandom); req0_cin = 1'($urandom);
        end
        if (!req1_valid && $urandom_range(99) < p1) begin
            req1_valid = 1'b1; req1_a = WIDTH'($urandom); req1_b = WIDTH'($urandom); req1_cin = 1'($urandom);
        end
        res_ready = ($urandom_range(99) < pr);
    endtask

    task automatic set0(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
        req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
    endtask

    task automatic set1(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
        req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
    endtask

    initial begin
        int start;
        rst_n = 1'b0; res_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        #2;
        check("rst_res_valid", res_valid, 0);
        check("rst_res_sum", res_sum, 0);
        check("rst_res_cout", res_cout, 0);
        check("rst_res_id", res_id, 0);
        check("rst_ops_cnt", ops_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single op with full carry propagation
        res_ready = 1'b1;
        set0(16'hFFFF, 16'h0001, 1'b0);
        cycle();
        cycle();
        #1;
        check("single_valid", res_valid, 1);
        check("single_sum", res_sum, 16'h0000);
        check("single_cout", res_cout, 1);
        check("single_id", res_id, 0);
        cycle();

        // Carry-in from requester 1
        set1(16'h7FFF, 16'h0000, 1'b1);
        cycle();
        cycle();
        #1;
        check("cin_valid", res_valid, 1);
        check("cin_sum", res_sum, 16'h8000);
        check("cin_cout", res_cout, 0);
        check("cin_id", res_id, 1);
        cycle();

        // Continuous contention at full throughput
        for (int k = 0; k < 24; k++) begin
            gen(100, 100, 100);
            cycle();
        end

        // Backpressure: drain, then block the consumer for 5 cycles with requests pending
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        dut_accepts = 0;
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            gen(100, 100, 0);
            cycle();
        end
        check("bp_accepts", dut_accepts, 2);
        for (int k = 0; k < 8; k++) begin
            gen(0, 0, 100);
            cycle();
        end

        // Randomised traffic with random backpressure
        for (int k = 0; k < 400; k++) begin
            gen(60, 60, 70);
            cycle();
        end

        // Counter wrap: 256 more results returns OPS_CNT to its starting value
        start = model_cnt;
        for (int k = 0; k < 700 && model_cnt < start + 256; k++) begin
            gen(100, 100, 100);
            cycle();
        end
        #1;
        check("cnt_wrap", ops_cnt, start % 256);

        // Reset mid-stream while a result is being held
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            gen(100, 100, 0);
            cycle();
        end
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check("midrst_res_valid", res_valid, 0);
        check("midrst_res_sum", res_sum, 0);
        check("midrst_res_cout", res_cout, 0);
        check("midrst_res_id", res_id, 0);
        check("midrst_ops_cnt", ops_cnt, 0);
        pipe_q.delete();
        model_cnt = 0; model_last = 1'b1; acc0 = 1'b0; acc1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) cycle();

        // First tie after reset goes to requester 0
        set0(16'h1234, 16'h4321, 1'b0);
        set1(16'hAAAA, 16'h5555, 1'b1);
        for (int k = 0; k < 6; k++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
